// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, address type and write-controller states
package fb_pkg;

    localparam int H_RES         = 320;
    localparam int V_RES         = 240;
    localparam int FB_PIXELS     = 76800;
    localparam int FB_ADDR_WIDTH = 17;

    typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        DRAW  = 1'b1
    } fbw_state_e;

endpackage

// File: rtl/vsync_edge_sync.sv
// rtl/vsync_edge_sync.sv - two-flop vsync synchronizer with falling-edge swap detect
module vsync_edge_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_vsync,
    output logic o_swap
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_vsync;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Same edge rule as the framebuffer, so both sides swap on the same cycle
    assign o_swap = r_prev & ~r_sync2;

endmodule

// File: rtl/fb_write_ctrl.sv
// rtl/fb_write_ctrl.sv - clears the back buffer after each swap, then writes rasterized pixels
module fb_write_ctrl #(
    parameter int         H_RES       = fb_pkg::H_RES,
    parameter int         V_RES       = fb_pkg::V_RES,
    parameter int         ADDR_WIDTH  = fb_pkg::FB_ADDR_WIDTH,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  pix_valid,
    input  logic [8:0]            pix_x,
    input  logic [7:0]            pix_y,
    input  logic [7:0]            pix_color,
    output logic                  pix_ready,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [7:0]            dina,
    output logic                  clearing,
    output logic                  frame_start
);

    import fb_pkg::*;

    localparam int                    FB_LAST   = H_RES * V_RES - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_LAST);
    localparam logic [8:0]            X_LIM     = 9'(H_RES);
    localparam logic [7:0]            Y_LIM     = 8'(V_RES);

    fbw_state_e            r_state;
    fbw_state_e            w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_next;
    logic                  r_wea;
    logic                  w_wea_next;
    logic [ADDR_WIDTH-1:0] r_addra;
    logic [ADDR_WIDTH-1:0] w_addra_next;
    logic [7:0]            r_dina;
    logic [7:0]            w_dina_next;
    logic                  r_frame_start;
    logic                  w_frame_start_next;
    logic                  w_pix_ready;
    logic                  w_swap;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_x_ext;
    logic [ADDR_WIDTH-1:0] w_y_ext;
    logic [ADDR_WIDTH-1:0] w_pix_addr;

    vsync_edge_sync u_vsync_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_vsync (vsync),
        .o_swap  (w_swap)
    );

    // y*320 + x as (y<<8) + (y<<6) + x
    assign w_x_ext    = ADDR_WIDTH'(pix_x);
    assign w_y_ext    = ADDR_WIDTH'(pix_y);
    assign w_pix_addr = (w_y_ext << 8) + (w_y_ext << 6) + w_x_ext;
    assign w_in_range = (pix_x < X_LIM) && (pix_y < Y_LIM);

    always_comb begin
        w_state_next       = r_state;
        w_clr_cnt_next     = r_clr_cnt;
        w_wea_next         = 1'b0;
        w_addra_next       = r_addra;
        w_dina_next        = r_dina;
        w_frame_start_next = 1'b0;
        w_pix_ready        = 1'b0;
        // A swap cycle never writes, so nothing from the old frame leaks into the new buffer
        if (w_swap) begin
            w_state_next   = CLEAR;
            w_clr_cnt_next = '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    w_wea_next   = 1'b1;
                    w_addra_next = r_clr_cnt;
                    w_dina_next  = CLEAR_COLOR;
                    if (r_clr_cnt == LAST_ADDR) begin
                        w_state_next       = DRAW;
                        w_clr_cnt_next     = '0;
                        w_frame_start_next = 1'b1;
                    end else begin
                        w_clr_cnt_next = r_clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                DRAW: begin
                    w_pix_ready = 1'b1;
                    if (pix_valid && w_in_range) begin
                        w_wea_next   = 1'b1;
                        w_addra_next = w_pix_addr;
                        w_dina_next  = pix_color;
                    end
                end
                default: begin
                    w_state_next   = CLEAR;
                    w_clr_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= CLEAR;
            r_clr_cnt     <= '0;
            r_wea         <= 1'b0;
            r_addra       <= '0;
            r_dina        <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_clr_cnt     <= w_clr_cnt_next;
            r_wea         <= w_wea_next;
            r_addra       <= w_addra_next;
            r_dina        <= w_dina_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign pix_ready   = w_pix_ready;
    assign wea         = r_wea;
    assign addra       = r_addra;
    assign dina        = r_dina;
    assign clearing    = (r_state == CLEAR);
    assign frame_start = r_frame_start;

endmodule
